// File: rtl/dmem_arbiter.sv
// Round-robin arbiter/sequencer sharing one word-addressed data memory
// between the CPU load/store port (port 0) and an auxiliary master (port 1).
module dmem_arbiter #(
    parameter int unsigned MEM_WORDS = 1024,
    parameter int unsigned DATA_W    = 32
) (
    input  logic              clk,
    input  logic              resetN,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [DATA_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_ack,
    output logic              p0_err,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [DATA_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_ack,
    output logic              p1_err,
    output logic [DATA_W-1:0] p1_rdata,
    output logic [DATA_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_wrData,
    output logic              mem_MemWrite,
    output logic              mem_MemRead,
    input  logic [DATA_W-1:0] mem_readData,
    output logic              busy
);

    localparam logic [DATA_W-1:0] ADDR_LIMIT = DATA_W'(MEM_WORDS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } state_t;

    state_t            state;
    state_t            next_state;
    logic              last_gnt;
    logic              gnt_id;
    logic              we_r;
    logic              in_range_r;
    logic [DATA_W-1:0] addr_r;
    logic [DATA_W-1:0] wdata_r;

    logic              grant_c;
    logic              sel_c;
    logic              in_range_c;
    logic [DATA_W-1:0] sel_addr_c;
    logic [DATA_W-1:0] rsp_c;

    // Next-state, grant selection and response data
    always_comb begin
        next_state = state;
        grant_c    = 1'b0;
        sel_c      = 1'b0;
        case (state)
            IDLE: begin
                if (p0_req || p1_req) begin
                    grant_c    = 1'b1;
                    // On a tie the port not granted last wins
                    sel_c      = (p0_req && p1_req) ? ~last_gnt : p1_req;
                    next_state = ACCESS;
                end
            end
            ACCESS:  next_state = ACK;
            ACK:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
        sel_addr_c = sel_c ? p1_addr : p0_addr;
        in_range_c = (sel_addr_c < ADDR_LIMIT);
        rsp_c      = (in_range_r && !we_r) ? mem_readData : '0;
    end

    // Strobes gated by reset so no write lands while reset is asserted
    assign mem_MemWrite = resetN && (state == ACCESS) && in_range_r && we_r;
    assign mem_MemRead  = resetN && (state == ACCESS) && in_range_r && !we_r;
    assign mem_address  = addr_r;
    assign mem_wrData   = wdata_r;

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state      <= IDLE;
            last_gnt   <= 1'b1;
            gnt_id     <= 1'b0;
            we_r       <= 1'b0;
            in_range_r <= 1'b0;
            addr_r     <= '0;
            wdata_r    <= '0;
            busy       <= 1'b0;
            p0_ack     <= 1'b0;
            p0_err     <= 1'b0;
            p0_rdata   <= '0;
            p1_ack     <= 1'b0;
            p1_err     <= 1'b0;
            p1_rdata   <= '0;
        end else begin
            state    <= next_state;
            busy     <= (next_state != IDLE);
            p0_ack   <= 1'b0;
            p0_err   <= 1'b0;
            p0_rdata <= '0;
            p1_ack   <= 1'b0;
            p1_err   <= 1'b0;
            p1_rdata <= '0;
            if (grant_c) begin
                gnt_id     <= sel_c;
                last_gnt   <= sel_c;
                we_r       <= sel_c ? p1_we : p0_we;
                addr_r     <= sel_addr_c;
                wdata_r    <= sel_c ? p1_wdata : p0_wdata;
                in_range_r <= in_range_c;
            end
            // Response captured at the edge closing ACCESS, shown during ACK
            if (state == ACCESS) begin
                if (gnt_id) begin
                    p1_ack   <= 1'b1;
                    p1_err   <= ~in_range_r;
                    p1_rdata <= rsp_c;
                end else begin
                    p0_ack   <= 1'b1;
                    p0_err   <= ~in_range_r;
                    p0_rdata <= rsp_c;
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural data memory model.
module tb_dmem_arbiter;

    logic        clk;
    logic        resetN;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic        p0_ack, p0_err, p1_ack, p1_err;
    logic [31:0] p0_rdata, p1_rdata;
    logic [31:0] mem_address, mem_wrData, mem_readData;
    logic        mem_MemWrite, mem_MemRead, busy;

    logic        mem_init;
    logic [31:0] tb_mem [0:1023];
    int          wr_cnt;
    int          overlap_cnt;
    int          vectors;
    int          miscompares;

    dmem_arbiter #(.MEM_WORDS(1024), .DATA_W(32)) dut (
        .clk(clk), .resetN(resetN),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_ack(p0_ack), .p0_err(p0_err), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_ack(p1_ack), .p1_err(p1_err), .p1_rdata(p1_rdata),
        .mem_address(mem_address), .mem_wrData(mem_wrData),
        .mem_MemWrite(mem_MemWrite), .mem_MemRead(mem_MemRead),
        .mem_readData(mem_readData), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] pat(input int i);
        return 32'h5A5A_0000 | 32'(i);
    endfunction

    // Memory model: combinational read, write on the rising edge
    assign mem_readData = tb_mem[mem_address[9:0]];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 1024; i++) tb_mem[i] <= pat(i);
            wr_cnt      <= 0;
            overlap_cnt <= 0;
        end else begin
            if (mem_MemWrite) begin
                tb_mem[mem_address[9:0]] <= mem_wrData;
                wr_cnt <= wr_cnt + 1;
            end
            if (mem_MemWrite && mem_MemRead) overlap_cnt <= overlap_cnt + 1;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset;
        int wbase;
        @(negedge clk);
        resetN = 1'b0;
        p0_req = 1'b1; p0_we = 1'b1; p0_addr = 32'd2; p0_wdata = 32'h1111_2222;
        p1_req = 1'b1; p1_we = 1'b1; p1_addr = 32'd3; p1_wdata = 32'h3333_4444;
        wbase = wr_cnt;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            vectors++;
            if ({p0_ack, p1_ack, p0_err, p1_err, p0_rdata, p1_rdata, mem_address, mem_wrData,
                 mem_MemWrite, mem_MemRead, busy} !== '0) begin
                miscompares++;
                $display("FAIL reset_outputs: got acks=%b%b errs=%b%b rd0=%h rd1=%h addr=%h wd=%h we=%b re=%b busy=%b expected all 0",
                         p0_ack, p1_ack, p0_err, p1_err, p0_rdata, p1_rdata, mem_address, mem_wrData,
                         mem_MemWrite, mem_MemRead, busy);
            end
        end
        vectors++;
        if (wr_cnt !== wbase) begin miscompares++; $display("FAIL reset_no_write: got %0d writes expected 0", wr_cnt - wbase); end
        resetN = 1'b1;
        @(negedge clk);
        vectors++;
        if (mem_address !== 32'd2 || mem_MemWrite !== 1'b1 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_first_grant: got addr=%h we=%b busy=%b expected addr=00000002 we=1 busy=1", mem_address, mem_MemWrite, busy);
        end
        @(negedge clk);
        vectors++;
        if (p0_ack !== 1'b1 || p1_ack !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_first_ack: got p0_ack=%b p1_ack=%b expected 1 0", p0_ack, p1_ack);
        end
        p0_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (mem_address !== 32'd3) begin miscompares++; $display("FAIL reset_second_grant: got addr=%h expected 00000003", mem_address); end
        @(negedge clk);
        vectors++;
        if (p1_ack !== 1'b1 || p0_ack !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_second_ack: got p0_ack=%b p1_ack=%b expected 0 1", p0_ack, p1_ack);
        end
        p1_req = 1'b0;
        @(negedge clk);
        vectors++;
        if (tb_mem[2] !== 32'h1111_2222 || tb_mem[3] !== 32'h3333_4444) begin
            miscompares++;
            $display("FAIL reset_mem: got m2=%h m3=%h expected 11112222 33334444", tb_mem[2], tb_mem[3]);
        end
    endtask

    task automatic test_single_port;
        int wbase;
        wbase = wr_cnt;
        p0_req = 1'b1; p0_we = 1'b1; p0_addr = 32'd5; p0_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        vectors++;
        if (mem_MemWrite !== 1'b1 || mem_MemRead !== 1'b0 || mem_address !== 32'd5 ||
            mem_wrData !== 32'hDEAD_BEEF || p0_ack !== 1'b0) begin
            miscompares++;
            $display("FAIL single_access: got we=%b re=%b addr=%h wd=%h ack=%b expected 1 0 00000005 deadbeef 0",
                     mem_MemWrite, mem_MemRead, mem_address, mem_wrData, p0_ack);
        end
        @(negedge clk);
        vectors++;
        if (p0_ack !== 1'b1 || p0_err !== 1'b0 || p0_rdata !== 32'h0 || mem_MemWrite !== 1'b0) begin
            miscompares++;
            $display("FAIL single_write_ack: got ack=%b err=%b rdata=%h we=%b expected 1 0 00000000 0",
                     p0_ack, p0_err, p0_rdata, mem_MemWrite);
        end
        p0_we = 1'b0; p0_wdata = 32'h0;
        @(negedge clk);
        vectors++;
        if (p0_ack !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL single_idle: got ack=%b busy=%b expected 0 0", p0_ack, busy);
        end
        @(negedge clk);
        vectors++;
        if (mem_MemRead !== 1'b1 || mem_MemWrite !== 1'b0) begin
            miscompares++;
            $display("FAIL single_read_strobe: got re=%b we=%b expected 1 0", mem_MemRead, mem_MemWrite);
        end
        @(negedge clk);
        vectors++;
        if (p0_ack !== 1'b1 || p0_err !== 1'b0 || p0_rdata !== 32'hDEAD_BEEF) begin
            miscompares++;
            $display("FAIL single_read_ack: got ack=%b err=%b rdata=%h expected 1 0 deadbeef", p0_ack, p0_err, p0_rdata);
        end
        p0_req = 1'b0;
        @(negedge clk);
        vectors++;
        if (wr_cnt - wbase !== 1) begin miscompares++; $display("FAIL single_write_count: got %0d expected 1", wr_cnt - wbase); end
    endtask

    task automatic test_contention;
        int j0, j1, t, ph;
        logic e0, e1, eb, ew;
        logic [31:0] ea;
        resetN = 1'b0;
        @(negedge clk);
        resetN = 1'b1;
        j0 = 0; j1 = 0;
        p0_req = 1'b1; p0_we = 1'b1; p0_addr = 32'd0;  p0_wdata = 32'h0000_1000;
        p1_req = 1'b1; p1_we = 1'b1; p1_addr = 32'd10; p1_wdata = 32'h0000_2000;
        for (int i = 1; i <= 24; i++) begin
            @(negedge clk);
            t  = (i - 1) / 3;
            ph = (i - 1) % 3;
            e0 = (ph == 1) && (t % 2 == 0);
            e1 = (ph == 1) && (t % 2 == 1);
            eb = (ph != 2);
            ew = (ph == 0);
            ea = (t % 2 == 1) ? 32'(10 + t / 2) : 32'(t / 2);
            vectors++;
            if (p0_ack !== e0 || p1_ack !== e1 || busy !== eb || mem_MemWrite !== ew) begin
                miscompares++;
                $display("FAIL contention_cycle%0d: got ack=%b%b busy=%b we=%b expected ack=%b%b busy=%b we=%b",
                         i, p0_ack, p1_ack, busy, mem_MemWrite, e0, e1, eb, ew);
            end
            if (ph == 0) begin
                vectors++;
                if (mem_address !== ea) begin
                    miscompares++;
                    $display("FAIL contention_grant%0d: got addr=%h expected %h", t, mem_address, ea);
                end
            end
            if (ph == 1) begin
                if (t % 2 == 0) begin
                    j0++;
                    if (j0 < 4) begin p0_addr = 32'(j0); p0_wdata = 32'h0000_1000 + 32'(j0); end
                    else p0_req = 1'b0;
                end else begin
                    j1++;
                    if (j1 < 4) begin p1_addr = 32'(10 + j1); p1_wdata = 32'h0000_2000 + 32'(j1); end
                    else p1_req = 1'b0;
                end
            end
        end
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (tb_mem[k] !== 32'h0000_1000 + 32'(k) || tb_mem[10 + k] !== 32'h0000_2000 + 32'(k)) begin
                miscompares++;
                $display("FAIL contention_mem%0d: got %h %h expected %h %h", k, tb_mem[k], tb_mem[10 + k],
                         32'h0000_1000 + 32'(k), 32'h0000_2000 + 32'(k));
            end
        end
    endtask

    task automatic test_out_of_range;
        int wbase;
        wbase = wr_cnt;
        p1_req = 1'b1; p1_we = 1'b1; p1_addr = 32'd1024; p1_wdata = 32'h1234_5678;
        for (int r = 0; r < 2; r++) begin
            @(negedge clk);
            vectors++;
            if (mem_MemWrite !== 1'b0 || mem_MemRead !== 1'b0 || busy !== 1'b1) begin
                miscompares++;
                $display("FAIL oor_strobes%0d: got we=%b re=%b busy=%b expected 0 0 1", r, mem_MemWrite, mem_MemRead, busy);
            end
            @(negedge clk);
            vectors++;
            if (p1_ack !== 1'b1 || p1_err !== 1'b1 || p1_rdata !== 32'h0 || p0_ack !== 1'b0 || p0_err !== 1'b0) begin
                miscompares++;
                $display("FAIL oor_ack%0d: got ack=%b err=%b rdata=%h p0_ack=%b p0_err=%b expected 1 1 00000000 0 0",
                         r, p1_ack, p1_err, p1_rdata, p0_ack, p0_err);
            end
            p1_we = 1'b0;
            if (r == 1) p1_req = 1'b0;
            @(negedge clk);
        end
        vectors++;
        if (tb_mem[0] !== 32'h0000_1000 || wr_cnt !== wbase) begin
            miscompares++;
            $display("FAIL oor_mem: got m0=%h writes=%0d expected 00001000 0", tb_mem[0], wr_cnt - wbase);
        end
    endtask

    task automatic test_reset_during_access;
        p0_req = 1'b1; p0_we = 1'b1; p0_addr = 32'd7; p0_wdata = 32'hCAFE_F00D;
        @(negedge clk);
        resetN = 1'b0;
        p0_req = 1'b0;
        #1;
        vectors++;
        if (mem_MemWrite !== 1'b0) begin miscompares++; $display("FAIL rda_strobe: got we=%b expected 0", mem_MemWrite); end
        @(negedge clk);
        vectors++;
        if (p0_ack !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL rda_in_reset: got ack=%b busy=%b expected 0 0", p0_ack, busy);
        end
        resetN = 1'b1;
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (p0_ack !== 1'b0 || busy !== 1'b0 || tb_mem[7] !== pat(7)) begin
            miscompares++;
            $display("FAIL rda_after: got ack=%b busy=%b m7=%h expected 0 0 %h", p0_ack, busy, tb_mem[7], pat(7));
        end
    endtask

    task automatic test_late_request;
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'd5;
        @(negedge clk);
        p1_req = 1'b1; p1_we = 1'b1; p1_addr = 32'd20; p1_wdata = 32'h0077_0077;
        @(negedge clk);
        vectors++;
        if (p0_ack !== 1'b1 || p0_rdata !== 32'hDEAD_BEEF || p1_ack !== 1'b0) begin
            miscompares++;
            $display("FAIL late_p0_ack: got ack=%b rdata=%h p1_ack=%b expected 1 deadbeef 0", p0_ack, p0_rdata, p1_ack);
        end
        p0_req = 1'b0;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL late_idle: got busy=%b expected 0", busy); end
        @(negedge clk);
        vectors++;
        if (mem_address !== 32'd20 || mem_MemWrite !== 1'b1) begin
            miscompares++;
            $display("FAIL late_p1_access: got addr=%h we=%b expected 00000014 1", mem_address, mem_MemWrite);
        end
        @(negedge clk);
        vectors++;
        if (p1_ack !== 1'b1 || p0_ack !== 1'b0 || p1_rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL late_p1_ack: got p1_ack=%b p0_ack=%b rdata=%h expected 1 0 00000000", p1_ack, p0_ack, p1_rdata);
        end
        p1_req = 1'b0;
        @(negedge clk);
        vectors++;
        if (tb_mem[20] !== 32'h0077_0077) begin miscompares++; $display("FAIL late_mem: got %h expected 00770077", tb_mem[20]); end
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        resetN = 1'b0; mem_init = 1'b1;
        p0_req = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0;
        p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0;
        repeat (2) @(negedge clk);
        mem_init = 1'b0;
        test_reset;
        test_single_port;
        test_contention;
        test_out_of_range;
        test_reset_during_access;
        test_late_request;
        vectors++;
        if (overlap_cnt !== 0) begin miscompares++; $display("FAIL strobe_overlap: got %0d cycles expected 0", overlap_cnt); end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
